oam_dma_ctrl: RTL and testbench
===============================

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 SHALL have parameter DMA_REG_ADDR, default 16'h4014, the CPU write address that triggers DMA.
REQ-002 SHALL have parameter XFER_LEN, default 256, the number of bytes per transfer.
REQ-003 SHALL have CLOCK_50 input 1: system clock; all logic on its rising edge.
REQ-004 SHALL have reset input 1: asynchronous, active-high.
REQ-005 SHALL have cpu_ce input 1: one-CLOCK_50 pulse marking each CPU cycle boundary.
REQ-006 SHALL have cpu_we input 1: CPU bus write strobe, qualified by cpu_ce.
REQ-007 SHALL have cpu_addr input 16 and cpu_wdata input 8: CPU bus address and write data.
REQ-008 SHALL have oam_base input 8: PPU OAMADDR value, sampled at trigger.
REQ-009 SHALL have mem_addr output 16 and mem_rd output 1: source-memory read port.
REQ-010 SHALL have mem_rdata input 8: read data, valid at the cpu_ce that ends the read cycle.
REQ-011 SHALL have oam_addr output 8, oam_data_in output 8 and oam_we output 1: OAM write port.
REQ-012 SHALL have oam_dma output 1, high while a transfer is in progress; the top level drives rdy = ~oam_dma.
REQ-013 SHALL have dma_done output 1: one-CLOCK_50 pulse after the last OAM write.

Function
REQ-014 SHALL trigger on cpu_ce & cpu_we & cpu_addr==DMA_REG_ADDR in IDLE; page P=cpu_wdata, base B=oam_base latched.
REQ-015 SHALL implement FSM IDLE->HALT->[ALIGN]->READ<->WRITE->IDLE, advancing only on cpu_ce.
REQ-016 HALT SHALL last exactly one CPU cycle (dummy cycle) after the trigger cycle.
REQ-017 SHALL keep a CPU-cycle parity bit toggled on every cpu_ce; ALIGN is entered from HALT only when parity is odd.
REQ-018 READ SHALL drive mem_addr={P,idx[7:0]} and mem_rd=1, then capture mem_rdata into a byte register at the closing cpu_ce.
REQ-019 WRITE SHALL drive oam_addr=(B+idx) mod 256, oam_data_in=the captured byte, and oam_we=1 for exactly one CLOCK_50 cycle coincident with the closing cpu_ce.
REQ-020 SHALL increment idx after each WRITE; after idx==XFER_LEN-1, return to IDLE and pulse dma_done.
REQ-021 Total halt SHALL be 513 CPU cycles (even parity) or 514 (odd parity).
REQ-022 oam_dma SHALL be registered: high from the cycle after the trigger through the final WRITE, low in IDLE.
REQ-023 SHALL ignore writes to DMA_REG_ADDR while a transfer is active.
REQ-024 SHALL hold mem_rd=0 and oam_we=0 outside READ and WRITE respectively.
REQ-025 OAM address overflow SHALL wrap mod 256 (B=8'hF0 -> ..., 8'hFF, 8'h00).

Reset
REQ-026 On reset SHALL set state=IDLE, idx=0, parity=0, oam_dma=0, mem_rd=0, oam_we=0, dma_done=0, and mem_addr, oam_addr and oam_data_in to 0.
REQ-027 Reset mid-transfer SHALL abort immediately with no further OAM writes; the next trigger starts a fresh transfer.

Configuration
REQ-028 SHALL support macro OAM_DMA_ALIGN_EN: when defined, the ALIGN state and parity tracking are built, giving 513/514 cycles.
REQ-029 Without OAM_DMA_ALIGN_EN, ALIGN and parity SHALL be omitted and the transfer SHALL always take 513 cycles.

Structure
REQ-030 Shared package nes_pkg SHALL hold the dma_state_t enum, DMA_REG_ADDR_DEFAULT, and the OAM_SIZE=256 constant.
REQ-031 SHALL be a single module with no sub-modules; the parity bit is local.

Verification
REQ-032 Write 8'h02 to 16'h4014 at even parity -> 513 cycles of oam_dma; OAM[i]=mem[16'h0200+i] for i=0..255; dma_done pulses once.
REQ-033 The same trigger at odd parity with OAM_DMA_ALIGN_EN defined -> 514 cycles; built without the macro -> 513 cycles.
REQ-034 oam_base=8'hF0, page 8'h03 -> byte 16'h0300 lands at OAM 8'hF0 and byte 16'h0310 lands at OAM 8'h00.
REQ-035 A second write to 16'h4014 at byte 100 -> ignored; the transfer completes from the original page.
REQ-036 Assert reset at byte 50 -> oam_dma=0 and no oam_we pulses; re-trigger with page 8'h07 -> full 513/514-cycle transfer from 16'h0700.
REQ-037 Write to 16'h4015 or 16'h2004 -> no trigger; oam_dma stays 0.

Source files
------------

// File: rtl/nes_pkg.sv
// nes_pkg -- constants and types shared by the NES-side blocks.
//   dma_state_t          : sprite-DMA controller state encoding
//   DMA_REG_ADDR_DEFAULT : CPU address of the OAMDMA register
//   OAM_SIZE             : bytes in primary OAM
package nes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR_DEFAULT = 16'h4014;
    localparam int          OAM_SIZE             = 256;

endpackage

// File: rtl/oam_dma.sv
// oam_dma_ctrl -- NES sprite DMA: copies XFER_LEN bytes from CPU page P
// into OAM starting at OAMADDR, halting the CPU while it runs.
//
// Build option: define OAM_DMA_ALIGN_EN to build the CPU-cycle parity bit
// and the ALIGN state (513 or 514 halted cycles). Without it the transfer
// is always 513 CPU cycles.
//
// Ports
//   CLOCK_50, reset        : clock (rising edge), async active-high reset
//   cpu_ce                 : one-clock pulse per CPU cycle boundary
//   cpu_we/addr/wdata      : CPU bus write (qualified by cpu_ce)
//   oam_base               : OAMADDR, latched at trigger
//   mem_addr/mem_rd/rdata  : source-memory read port
//   oam_addr/data_in/we    : OAM write port
//   oam_dma                : transfer in progress (rdy = ~oam_dma at top)
//   dma_done               : one-clock pulse after the last OAM write
module oam_dma_ctrl
    import nes_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEFAULT,
    parameter int          XFER_LEN     = OAM_SIZE
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        cpu_ce,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic [7:0]  oam_base,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data_in,
    output logic        oam_we,
    output logic        oam_dma,
    output logic        dma_done
);

    localparam logic [8:0] LAST_IDX = 9'(XFER_LEN - 1);

    dma_state_t state_q, state_d;
    logic [8:0] idx_q,   idx_d;
    logic [7:0] page_q,  page_d;
    logic [7:0] base_q,  base_d;
    logic [7:0] data_q,  data_d;
    logic       oam_dma_q, oam_dma_d;
    logic       done_q,    done_d;
    logic       trigger;

`ifdef OAM_DMA_ALIGN_EN
    // Parity of the current CPU cycle; flips on every cpu_ce.
    logic parity_q, parity_d;
    assign parity_d = cpu_ce ? ~parity_q : parity_q;
`endif

    assign trigger = cpu_ce & cpu_we & (cpu_addr == DMA_REG_ADDR);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        page_d    = page_q;
        base_d    = base_q;
        data_d    = data_q;
        oam_dma_d = oam_dma_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Writes to the register are only honoured here, so a
                // second write mid-transfer is simply dropped.
                if (trigger) begin
                    state_d   = ST_HALT;
                    page_d    = cpu_wdata;
                    base_d    = oam_base;
                    idx_d     = '0;
                    oam_dma_d = 1'b1;
                end
            end
            ST_HALT: begin
                if (cpu_ce) begin
`ifdef OAM_DMA_ALIGN_EN
                    // Dummy cycle landed on an odd cycle: burn one more so
                    // reads fall on the proper half of the CPU cycle pair.
                    state_d = parity_q ? ST_ALIGN : ST_READ;
`else
                    state_d = ST_READ;
`endif
                end
            end
            ST_ALIGN: begin
                if (cpu_ce) state_d = ST_READ;
            end
            ST_READ: begin
                if (cpu_ce) begin
                    data_d  = mem_rdata;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (cpu_ce) begin
                    if (idx_q == LAST_IDX) begin
                        state_d   = ST_IDLE;
                        oam_dma_d = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        idx_d   = idx_q + 9'd1;
                        state_d = ST_READ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            page_q    <= '0;
            base_q    <= '0;
            data_q    <= '0;
            oam_dma_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            page_q    <= page_d;
            base_q    <= base_d;
            data_q    <= data_d;
            oam_dma_q <= oam_dma_d;
            done_q    <= done_d;
        end
    end

`ifdef OAM_DMA_ALIGN_EN
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) parity_q <= 1'b0;
        else       parity_q <= parity_d;
    end
`endif

    // Port outputs decode from registered state, so they are all zero in
    // reset/IDLE. oam_we is qualified by cpu_ce to give one write pulse
    // at the close of each WRITE cycle.
    assign mem_rd      = (state_q == ST_READ);
    assign mem_addr    = mem_rd ? {page_q, idx_q[7:0]} : 16'h0000;
    assign oam_we      = (state_q == ST_WRITE) & cpu_ce;
    assign oam_addr    = (state_q == ST_WRITE) ? (base_q + idx_q[7:0]) : 8'h00;
    assign oam_data_in = (state_q == ST_WRITE) ? data_q : 8'h00;
    assign oam_dma     = oam_dma_q;
    assign dma_done    = done_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl -- directed bench for oam_dma_ctrl. A CPU cycle is three
// CLOCK_50 cycles with cpu_ce high in the last. Expected OAM contents come
// from the same source-memory function the bench drives onto mem_rdata.
module tb_oam_dma_ctrl;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    logic        cpu_ce   = 1'b0;
    logic        cpu_we   = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [7:0]  oam_base = 8'h00;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data_in;
    logic        oam_we;
    logic        oam_dma;
    logic        dma_done;

    int errors = 0;
    int checks = 0;
    int n_ce   = 0;  // cpu_ce pulses issued since last reset

    // Monitor-owned counters (only read elsewhere, via snapshots).
    int dma_ce   = 0;
    int we_cnt   = 0;
    int done_cnt = 0;
    int bad_we   = 0;
    logic [7:0] oam [256];

    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic logic [7:0] mem_fn(input logic [15:0] a);
        return (a[7:0] ^ {a[11:8], a[15:12]}) + 8'h3C;
    endfunction

    assign mem_rdata = mem_rd ? mem_fn(mem_addr) : 8'h00;

    oam_dma_ctrl dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .cpu_ce     (cpu_ce),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .oam_base   (oam_base),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .oam_addr   (oam_addr),
        .oam_data_in(oam_data_in),
        .oam_we     (oam_we),
        .oam_dma    (oam_dma),
        .dma_done   (dma_done)
    );

    always @(posedge CLOCK_50) begin
        if (cpu_ce && oam_dma) dma_ce <= dma_ce + 1;
        if (oam_we) begin
            oam[oam_addr] <= oam_data_in;
            we_cnt        <= we_cnt + 1;
            if (!cpu_ce) bad_we <= bad_we + 1;
        end
        if (dma_done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cpu_cycle(input logic we, input logic [15:0] a, input logic [7:0] d);
        @(negedge CLOCK_50);
        cpu_ce = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        n_ce++;
        @(negedge CLOCK_50);
        cpu_ce = 1'b0; cpu_we = 1'b0;
        @(negedge CLOCK_50);
    endtask

    task automatic pulse_reset();
        @(negedge CLOCK_50);
        #3 reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        n_ce  = 0;
    endtask

    // Make the dummy (HALT) cycle land on odd parity when want_odd is set.
    // HALT parity = (ce pulses before trigger + 1) mod 2.
    task automatic set_parity(input bit want_odd);
        if (((n_ce + 1) % 2 == 1) != want_odd) cpu_cycle(1'b0, 16'h0000, 8'h00);
    endtask

    function automatic int exp_len(input bit odd);
`ifdef OAM_DMA_ALIGN_EN
        return odd ? 514 : 513;
`else
        return (odd && 1'b0) ? 514 : 513;
`endif
    endfunction

    task automatic wait_done(input int done0);
        int k;
        k = 0;
        while (done_cnt == done0 && k < 700) begin
            cpu_cycle(1'b0, 16'h0000, 8'h00);
            k++;
        end
        chk("done_timeout", (done_cnt == done0), 0);
        repeat (2) cpu_cycle(1'b0, 16'h0000, 8'h00);
    endtask

    task automatic verify_oam(input string tag, input logic [7:0] page, input logic [7:0] base);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] ia;
            ia = base + 8'(i);
            if (oam[ia] !== mem_fn({page, 8'(i)})) bad++;
        end
        chk(tag, bad, 0);
    endtask

    task automatic run_xfer(input string tag, input logic [7:0] page, input logic [7:0] base,
                            input bit odd);
        int c0, w0, d0;
        set_parity(odd);
        oam_base = base;
        c0 = dma_ce; w0 = we_cnt; d0 = done_cnt;
        cpu_cycle(1'b1, 16'h4014, page);
        wait_done(d0);
        chk({tag, "_len"},  dma_ce - c0,  exp_len(odd));
        chk({tag, "_we"},   we_cnt - w0,  256);
        chk({tag, "_done"}, done_cnt - d0, 1);
        chk({tag, "_idle"}, oam_dma, 0);
        verify_oam({tag, "_oam"}, page, base);
    endtask

    initial begin
        int c0, w0, d0;
        repeat (3) @(negedge CLOCK_50);
        // Reset state
        chk("rst_oam_dma", oam_dma, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_oam_we", oam_we, 0);
        chk("rst_done", dma_done, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_oam_addr", oam_addr, 0);
        chk("rst_oam_data", oam_data_in, 0);
        reset = 1'b0;
        n_ce  = 0;

        // Writes to neighbouring registers do not trigger
        c0 = dma_ce;
        cpu_cycle(1'b1, 16'h4015, 8'h02);
        cpu_cycle(1'b1, 16'h2004, 8'h02);
        cpu_cycle(1'b0, 16'h4014, 8'h02);  // read, not write
        repeat (4) cpu_cycle(1'b0, 16'h0000, 8'h00);
        chk("notrig_dma", oam_dma, 0);
        chk("notrig_cnt", dma_ce - c0, 0);

        // Basic transfer, even parity
        run_xfer("even", 8'h02, 8'h00, 1'b0);
        chk("even_oam0",   oam[8'h00], mem_fn(16'h0200));
        chk("even_oam255", oam[8'hFF], mem_fn(16'h02FF));

        // Odd parity: ALIGN adds a cycle only when built in
        run_xfer("odd", 8'h05, 8'h00, 1'b1);

        // OAM address wrap
        run_xfer("wrap", 8'h03, 8'hF0, 1'b0);
        chk("wrap_F0", oam[8'hF0], mem_fn(16'h0300));
        chk("wrap_00", oam[8'h00], mem_fn(16'h0310));
        chk("wrap_EF", oam[8'hEF], mem_fn(16'h03FF));

        // Second trigger at byte 100 is ignored
        set_parity(1'b0);
        oam_base = 8'h00;
        c0 = dma_ce; w0 = we_cnt; d0 = done_cnt;
        cpu_cycle(1'b1, 16'h4014, 8'h04);
        for (int k = 0; k < 400 && (we_cnt - w0) < 100; k++) cpu_cycle(1'b0, 16'h0000, 8'h00);
        chk("retrig_at100", we_cnt - w0, 100);
        cpu_cycle(1'b1, 16'h4014, 8'h09);
        wait_done(d0);
        chk("retrig_len", dma_ce - c0, 513);
        chk("retrig_we", we_cnt - w0, 256);
        chk("retrig_done", done_cnt - d0, 1);
        verify_oam("retrig_oam", 8'h04, 8'h00);

        // Reset at byte 50 aborts
        set_parity(1'b0);
        w0 = we_cnt; d0 = done_cnt;
        cpu_cycle(1'b1, 16'h4014, 8'h06);
        for (int k = 0; k < 200 && (we_cnt - w0) < 50; k++) cpu_cycle(1'b0, 16'h0000, 8'h00);
        chk("abort_at50", we_cnt - w0, 50);
        pulse_reset();
        chk("abort_dma", oam_dma, 0);
        chk("abort_mem_rd", mem_rd, 0);
        repeat (10) cpu_cycle(1'b0, 16'h0000, 8'h00);
        chk("abort_no_we", we_cnt - w0, 50);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_dma_idle", oam_dma, 0);
        run_xfer("fresh", 8'h07, 8'h00, 1'b0);
        run_xfer("fresh_odd", 8'h07, 8'h20, 1'b1);

        chk("we_outside_ce", bad_we, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
